// File: rtl/sa_ram_rwsp_fifo_ctrl.sv
// Valid/ready FIFO controller for a separate-read/write-port RAM with a registered
// read address (captured on re) and a registered output (captured on ore).
module sa_ram_rwsp_fifo_ctrl #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 14,
    parameter int unsigned CW = AW + 1
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          in_pvld,
    output logic          in_prdy,
    input  logic [DW-1:0] in_pd,
    output logic          out_pvld,
    input  logic          out_prdy,
    output logic [DW-1:0] out_pd,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    output logic          ram_ore,
    input  logic [DW-1:0] ram_dout,
    output logic [31:0]   ram_pwrbus_pd,
    output logic [CW-1:0] fifo_count,
    output logic          fifo_idle
);

    localparam logic [CW-1:0] Depth = CW'(2 ** AW);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] avail_q, avail_d;
    logic [CW-1:0] count_q, count_d;
    logic          s1_vld_q, s1_vld_d;
    logic          s2_vld_q, s2_vld_d;
    logic          push, pop;

    assign in_prdy       = (count_q < Depth);
    assign push          = in_pvld & in_prdy;
    assign ram_we        = push;
    assign ram_wa        = wr_ptr_q;
    assign ram_di        = in_pd;

    assign out_pvld      = s2_vld_q;
    assign out_pd        = ram_dout;
    assign pop           = out_pvld & out_prdy;

    // Output register advances only when it is empty or being drained this cycle.
    assign ram_ore       = s1_vld_q & (~s2_vld_q | pop);
    // avail lags push by a cycle, so a freshly written address is never read in the same cycle.
    assign ram_re        = (avail_q != '0) & (~s1_vld_q | ram_ore);
    assign ram_ra        = rd_ptr_q;

    assign ram_pwrbus_pd = '0;
    assign fifo_count    = count_q;
    assign fifo_idle     = (count_q == '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        avail_d  = avail_q;
        count_d  = count_q;
        s1_vld_d = s1_vld_q;
        s2_vld_d = s2_vld_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (ram_re) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({push, ram_re})
            2'b10:   avail_d = avail_q + CW'(1);
            2'b01:   avail_d = avail_q - CW'(1);
            default: avail_d = avail_q;
        endcase

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (ram_re) begin
            s1_vld_d = 1'b1;
        end else if (ram_ore) begin
            s1_vld_d = 1'b0;
        end

        if (ram_ore) begin
            s2_vld_d = 1'b1;
        end else if (pop) begin
            s2_vld_d = 1'b0;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            avail_q  <= '0;
            count_q  <= '0;
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            avail_q  <= avail_d;
            count_q  <= count_d;
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
        end
    end

endmodule

// File: tb/tb_sa_ram_rwsp_fifo_ctrl.sv
// Directed bench for sa_ram_rwsp_fifo_ctrl with a behavioural two-stage RAM and an
// in-order scoreboard of accepted write data.
module tb_sa_ram_rwsp_fifo_ctrl;

    logic        clk;
    logic        rstn;
    logic        in_pvld;
    logic        in_prdy;
    logic [13:0] in_pd;
    logic        out_pvld;
    logic        out_prdy;
    logic [13:0] out_pd;
    logic [7:0]  ram_wa;
    logic        ram_we;
    logic [13:0] ram_di;
    logic [7:0]  ram_ra;
    logic        ram_re;
    logic        ram_ore;
    logic [13:0] ram_dout;
    logic [31:0] ram_pwrbus_pd;
    logic [8:0]  fifo_count;
    logic        fifo_idle;

    int checks;
    int errors;

    logic [13:0] exp_q[$];
    logic [13:0] mem[256];
    logic [7:0]  ra_q;

    // Values sampled on the falling edge of the most recent cycle.
    logic        s_push, s_pop, s_vld, s_in_prdy, s_re, s_ore, s_we, s_idle;
    logic [13:0] s_pd, s_di;
    logic [7:0]  s_ra, s_wa;
    logic [8:0]  s_count;

    sa_ram_rwsp_fifo_ctrl #(.AW(8), .DW(14), .CW(9)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .in_pvld        (in_pvld),
        .in_prdy        (in_prdy),
        .in_pd          (in_pd),
        .out_pvld       (out_pvld),
        .out_prdy       (out_prdy),
        .out_pd         (out_pd),
        .ram_wa         (ram_wa),
        .ram_we         (ram_we),
        .ram_di         (ram_di),
        .ram_ra         (ram_ra),
        .ram_re         (ram_re),
        .ram_ore        (ram_ore),
        .ram_dout       (ram_dout),
        .ram_pwrbus_pd  (ram_pwrbus_pd),
        .fifo_count     (fifo_count),
        .fifo_idle      (fifo_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
        if (ram_ore) ram_dout <= mem[ra_q];
    end

    // One clock cycle: drive inputs, sample on negedge, return 1 time unit after posedge.
    task automatic cyc(input logic pv, input logic [13:0] pd, input logic rdy);
        in_pvld  = pv;
        in_pd    = pd;
        out_prdy = rdy;
        @(negedge clk);
        s_push    = in_pvld & in_prdy;
        s_pop     = out_pvld & out_prdy;
        s_vld     = out_pvld;
        s_pd      = out_pd;
        s_in_prdy = in_prdy;
        s_re      = ram_re;
        s_ore     = ram_ore;
        s_ra      = ram_ra;
        s_we      = ram_we;
        s_wa      = ram_wa;
        s_di      = ram_di;
        s_count   = fifo_count;
        s_idle    = fifo_idle;
        if (s_push) exp_q.push_back(pd);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_pvld  = 1'b0;
        in_pd    = '0;
        out_prdy = 1'b0;
        rstn     = 1'b0;
        #23;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        cyc(1'b0, 14'h0, 1'b0);
        checks++;
        if (s_in_prdy !== 1'b1) begin errors++; $display("FAIL rst_in_prdy got %b want 1", s_in_prdy); end
        checks++;
        if (s_vld !== 1'b0) begin errors++; $display("FAIL rst_out_pvld got %b want 0", s_vld); end
        checks++;
        if (s_count !== 9'd0 || s_idle !== 1'b1) begin
            errors++; $display("FAIL rst_count got %0d/%b want 0/1", s_count, s_idle);
        end
        checks++;
        if (s_re !== 1'b0 || s_ore !== 1'b0 || ram_pwrbus_pd !== 32'h0) begin
            errors++; $display("FAIL rst_ram got re=%b ore=%b pwr=%0h want 0", s_re, s_ore, ram_pwrbus_pd);
        end
    endtask

    task automatic test_single();
        cyc(1'b1, 14'h1A5, 1'b1);
        checks++;
        if (s_we !== 1'b1 || s_wa !== 8'd0 || s_di !== 14'h1A5) begin
            errors++; $display("FAIL single_write got we=%b wa=%0h di=%0h want 1/0/1a5", s_we, s_wa, s_di);
        end
        cyc(1'b0, 14'h0, 1'b1);
        checks++;
        if (s_re !== 1'b1 || s_ra !== 8'd0 || s_vld !== 1'b0 || s_count !== 9'd1) begin
            errors++; $display("FAIL single_c1 got re=%b ra=%0h vld=%b cnt=%0d want 1/0/0/1", s_re, s_ra, s_vld, s_count);
        end
        cyc(1'b0, 14'h0, 1'b1);
        checks++;
        if (s_ore !== 1'b1 || s_re !== 1'b0 || s_vld !== 1'b0) begin
            errors++; $display("FAIL single_c2 got ore=%b re=%b vld=%b want 1/0/0", s_ore, s_re, s_vld);
        end
        cyc(1'b0, 14'h0, 1'b1);
        checks++;
        if (s_vld !== 1'b1 || s_pd !== 14'h1A5) begin
            errors++; $display("FAIL single_c3 got vld=%b pd=%0h want 1/1a5", s_vld, s_pd);
        end
        cyc(1'b0, 14'h0, 1'b1);
        checks++;
        if (s_count !== 9'd0 || s_idle !== 1'b1 || s_vld !== 1'b0) begin
            errors++; $display("FAIL single_c4 got cnt=%0d idle=%b vld=%b want 0/1/0", s_count, s_idle, s_vld);
        end
        exp_q.delete();
    endtask

    task automatic drain(input string name, input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) begin
            cyc(1'b0, 14'h0, 1'b1);
            if (s_pop) begin
                checks++;
                if (exp_q.size() == 0 || s_pd !== exp_q[0]) begin
                    errors++; $display("FAIL %s_data got %0h want %0h", name, s_pd, exp_q.size() ? exp_q[0] : 14'h0);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL %s_drain got %0d left want 0", name, exp_q.size());
        end
        cyc(1'b0, 14'h0, 1'b1);
        checks++;
        if (s_count !== 9'd0 || s_vld !== 1'b0) begin
            errors++; $display("FAIL %s_empty got cnt=%0d vld=%b want 0/0", name, s_count, s_vld);
        end
    endtask

    task automatic pop_check(input string name);
        if (s_pop) begin
            checks++;
            if (exp_q.size() == 0 || s_pd !== exp_q[0]) begin
                errors++; $display("FAIL %s_data got %0h want %0h", name, s_pd, exp_q.size() ? exp_q[0] : 14'h0);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
    endtask

    task automatic test_streaming();
        int npop;
        int nrdy0;
        npop  = 0;
        nrdy0 = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 14'(i), 1'b1);
            if (!s_in_prdy) nrdy0++;
            if (s_pop) npop++;
            pop_check("stream");
        end
        checks++;
        if (nrdy0 != 0) begin errors++; $display("FAIL stream_in_prdy got %0d stalls want 0", nrdy0); end
        checks++;
        if (npop != 297) begin errors++; $display("FAIL stream_rate got %0d pops want 297", npop); end
        drain("stream", 20);
    endtask

    task automatic test_full();
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, 14'(i + 1000), 1'b0);
        end
        cyc(1'b1, 14'h2222, 1'b0);
        checks++;
        if (s_count !== 9'd256 || s_in_prdy !== 1'b0 || s_push !== 1'b0) begin
            errors++; $display("FAIL full_state got cnt=%0d rdy=%b push=%b want 256/0/0", s_count, s_in_prdy, s_push);
        end
        cyc(1'b1, 14'h2222, 1'b1);
        checks++;
        if (s_pop !== 1'b1 || s_push !== 1'b0) begin
            errors++; $display("FAIL full_pop got pop=%b push=%b want 1/0", s_pop, s_push);
        end
        pop_check("full");
        cyc(1'b1, 14'h3333, 1'b0);
        checks++;
        if (s_in_prdy !== 1'b1 || s_push !== 1'b1) begin
            errors++; $display("FAIL full_refill got rdy=%b push=%b want 1/1", s_in_prdy, s_push);
        end
        drain("full", 300);
    endtask

    task automatic test_stall();
        logic [13:0] held;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 14'(i + 500), 1'b1);
            pop_check("stall");
        end
        held = out_pd;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 14'(i + 600), 1'b0);
            checks++;
            if (s_vld !== 1'b1 || s_pd !== held || s_ore !== 1'b0 || s_re !== 1'b0) begin
                errors++; $display("FAIL stall_hold got vld=%b pd=%0h ore=%b re=%b want 1/%0h/0/0", s_vld, s_pd, s_ore, s_re, held);
            end
        end
        drain("stall", 40);
    endtask

    task automatic test_simul();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 14'(i + 700), 1'b0);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 14'h0, 1'b0);
        cyc(1'b1, 14'h0777, 1'b1);
        checks++;
        if (s_count !== 9'd10 || s_push !== 1'b1 || s_pop !== 1'b1) begin
            errors++; $display("FAIL simul_both got cnt=%0d push=%b pop=%b want 10/1/1", s_count, s_push, s_pop);
        end
        pop_check("simul");
        cyc(1'b0, 14'h0, 1'b0);
        checks++;
        if (s_count !== 9'd10) begin errors++; $display("FAIL simul_count got %0d want 10", s_count); end
        drain("simul", 40);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 14'(i + 900), 1'b1);
        in_pvld = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        checks++;
        if (out_pvld !== 1'b0 || fifo_count !== 9'd0 || in_prdy !== 1'b1 || fifo_idle !== 1'b1) begin
            errors++; $display("FAIL arst_clear got vld=%b cnt=%0d rdy=%b idle=%b want 0/0/1/1", out_pvld, fifo_count, in_prdy, fifo_idle);
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        cyc(1'b1, 14'h3FFF, 1'b1);
        cyc(1'b0, 14'h0, 1'b1);
        cyc(1'b0, 14'h0, 1'b1);
        checks++;
        if (s_vld !== 1'b0) begin errors++; $display("FAIL arst_early got vld=%b want 0", s_vld); end
        cyc(1'b0, 14'h0, 1'b1);
        checks++;
        if (s_vld !== 1'b1 || s_pd !== 14'h3FFF) begin
            errors++; $display("FAIL arst_new got vld=%b pd=%0h want 1/3fff", s_vld, s_pd);
        end
        pop_check("arst");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_streaming();
        test_full();
        test_stall();
        test_simul();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
